// File: rtl/flag_hazard_controller_pkg.sv
// Shared definitions for the flag hazard controller: ARM condition codes,
// NZCV bit positions and the controller state encoding.
package flag_hazard_controller_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_FLAGS = 2'd1,
        ST_FLUSH      = 2'd2
    } state_e;

endpackage

// File: rtl/flag_hazard_controller_if.sv
// ID/EXE-side signal bundle of the flag hazard controller; the pipeline
// drives through the master modport, the controller sits on the slave one.
interface flag_hazard_controller_if;

    logic       id_valid;
    logic [3:0] id_cond;
    logic       id_set_flags;
    logic       id_is_branch;
    logic       exe_sr_valid;
    logic [3:0] exe_sr;
    logic [3:0] sr;
    logic       issue;
    logic       squash;
    logic       stall;
    logic       branch_taken;
    logic       flush;
    logic       err;

    modport master (
        output id_valid, id_cond, id_set_flags, id_is_branch,
        output exe_sr_valid, exe_sr,
        input  sr, issue, squash, stall, branch_taken, flush, err
    );

    modport slave (
        input  id_valid, id_cond, id_set_flags, id_is_branch,
        input  exe_sr_valid, exe_sr,
        output sr, issue, squash, stall, branch_taken, flush, err
    );

endinterface

// File: rtl/flag_hazard_controller_cond_eval.sv
// Pure combinational ARM condition-code evaluation against an NZCV vector.
module flag_hazard_controller_cond_eval
    import flag_hazard_controller_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       met_o
);

    logic n, z, c, v;

    assign n = nzcv_i[FLAG_N];
    assign z = nzcv_i[FLAG_Z];
    assign c = nzcv_i[FLAG_C];
    assign v = nzcv_i[FLAG_V];

    always_comb begin
        met_o = 1'b0;
        case (cond_i)
            COND_EQ: met_o = z;
            COND_NE: met_o = ~z;
            COND_CS: met_o = c;
            COND_CC: met_o = ~c;
            COND_MI: met_o = n;
            COND_PL: met_o = ~n;
            COND_VS: met_o = v;
            COND_VC: met_o = ~v;
            COND_HI: met_o = c & ~z;
            COND_LS: met_o = ~c | z;
            COND_GE: met_o = (n == v);
            COND_LT: met_o = (n != v);
            COND_GT: met_o = ~z & (n == v);
            COND_LE: met_o = z | (n != v);
            COND_AL: met_o = 1'b1;
            COND_NV: met_o = 1'b0;
            default: met_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_hazard_controller.sv
// ID->EX conditional-execution sequencer: holds NZCV, tracks in-flight flag
// writers, stalls/forwards for flag hazards and runs the post-branch flush.
module flag_hazard_controller
    import flag_hazard_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_PENDING  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    flag_hazard_controller_if.slave  bus
);

    localparam logic [1:0] MAX_PEND   = 2'(MAX_PENDING);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] pending_q, pending_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [3:0] sr_q, sr_d;
    logic       err_q, err_d;

    logic       fwd;
    logic [3:0] eval_flags;
    logic       cond_met;
    logic       is_al;
    logic       flags_ready;
    logic       slot_free;
    logic       issue_w, squash_w, stall_w, branch_w;
    logic       inc, dec;

    // Forwarding is only safe when the returning flags belong to the last writer.
    assign fwd        = bus.exe_sr_valid && (pending_q == 2'd1);
    assign eval_flags = fwd ? bus.exe_sr : sr_q;

    flag_hazard_controller_cond_eval u_cond_eval (
        .cond_i (bus.id_cond),
        .nzcv_i (eval_flags),
        .met_o  (cond_met)
    );

    assign is_al       = (bus.id_cond == COND_AL);
    assign flags_ready = is_al || (pending_q == 2'd0) || fwd;
    assign slot_free   = !(bus.id_set_flags && (pending_q == MAX_PEND) && !bus.exe_sr_valid);

    always_comb begin
        issue_w     = 1'b0;
        squash_w    = 1'b0;
        stall_w     = 1'b0;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN, ST_WAIT_FLAGS: begin
                state_d = ST_RUN;
                if (bus.id_valid) begin
                    if (flags_ready && slot_free) begin
                        issue_w  = is_al || cond_met;
                        squash_w = !(is_al || cond_met);
                    end else begin
                        stall_w = 1'b1;
                        if (!flags_ready) begin
                            state_d = ST_WAIT_FLAGS;
                        end
                    end
                end
                if (issue_w && bus.id_is_branch) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LAST;
                end
            end
            ST_FLUSH: begin
                squash_w = bus.id_valid;
                if (flush_cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign branch_w = issue_w && bus.id_is_branch;

    assign inc = issue_w && bus.id_set_flags;
    assign dec = bus.exe_sr_valid && (pending_q != 2'd0);

    always_comb begin
        pending_d = pending_q;
        case ({inc, dec})
            2'b10:   pending_d = pending_q + 2'd1;
            2'b01:   pending_d = pending_q - 2'd1;
            default: pending_d = pending_q;
        endcase
    end

    // A flag return with nothing in flight is a protocol error and is ignored.
    assign sr_d  = dec ? bus.exe_sr : sr_q;
    assign err_d = err_q | (bus.exe_sr_valid && (pending_q == 2'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pending_q   <= 2'd0;
            flush_cnt_q <= 3'd0;
            sr_q        <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            flush_cnt_q <= flush_cnt_d;
            sr_q        <= sr_d;
            err_q       <= err_d;
        end
    end

    assign bus.sr           = sr_q;
    assign bus.issue        = issue_w;
    assign bus.squash       = squash_w;
    assign bus.stall        = stall_w;
    assign bus.branch_taken = branch_w;
    assign bus.flush        = (state_q == ST_FLUSH);
    assign bus.err          = err_q;

endmodule

// File: tb/tb_flag_hazard_controller.sv
// Directed bench for flag_hazard_controller with a cycle-level reference
// model of the conditional-issue rules and literal spot checks.
module tb_flag_hazard_controller;

    localparam int FC = 2;
    localparam int MP = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    flag_hazard_controller_if bus ();

    flag_hazard_controller #(
        .FLUSH_CYCLES (FC),
        .MAX_PENDING  (MP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Condition = base test selected by cond[3:1], inverted by cond[0].
    function automatic logic ref_met(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    int         m_pend;
    int         m_flush_left;
    logic [3:0] m_sr;
    logic       m_err;
    logic       e_issue, e_squash, e_stall, e_bt;
    logic [3:0] m_flags;

    always_comb begin
        e_issue  = 1'b0;
        e_squash = 1'b0;
        e_stall  = 1'b0;
        m_flags  = (bus.exe_sr_valid && m_pend == 1) ? bus.exe_sr : m_sr;
        if (bus.id_valid) begin
            if (m_flush_left > 0) begin
                e_squash = 1'b1;
            end else if ((bus.id_cond != 4'hE && !(m_pend == 0 || (m_pend == 1 && bus.exe_sr_valid)))
                         || (bus.id_set_flags && m_pend == MP && !bus.exe_sr_valid)) begin
                e_stall = 1'b1;
            end else if (ref_met(bus.id_cond, m_flags)) begin
                e_issue = 1'b1;
            end else begin
                e_squash = 1'b1;
            end
        end
        e_bt = e_issue && bus.id_is_branch;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend       <= 0;
            m_flush_left <= 0;
            m_sr         <= 4'h0;
            m_err        <= 1'b0;
        end else begin
            if (bus.exe_sr_valid && m_pend == 0) m_err <= 1'b1;
            if (bus.exe_sr_valid && m_pend > 0) m_sr <= bus.exe_sr;
            m_pend <= m_pend + ((e_issue && bus.id_set_flags) ? 1 : 0)
                             - ((bus.exe_sr_valid && m_pend > 0) ? 1 : 0);
            m_flush_left <= e_bt ? FC : ((m_flush_left > 0) ? m_flush_left - 1 : 0);
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk1("issue",        bus.issue,        e_issue);
            chk1("squash",       bus.squash,       e_squash);
            chk1("stall",        bus.stall,        e_stall);
            chk1("branch_taken", bus.branch_taken, e_bt);
            chk1("flush",        bus.flush,        m_flush_left > 0);
            chk4("sr",           bus.sr,           m_sr);
            chk1("err",          bus.err,          m_err);
        end
    end

    task automatic drive(input logic v, input logic [3:0] c, input logic sf, input logic br,
                         input logic ev, input logic [3:0] e);
        @(posedge clk);
        #1;
        bus.id_valid     = v;
        bus.id_cond      = c;
        bus.id_set_flags = sf;
        bus.id_is_branch = br;
        bus.exe_sr_valid = ev;
        bus.exe_sr       = e;
        #2;
    endtask

    initial begin
        logic [3:0] sr_vals [7];
        checks = 0;
        errors = 0;
        sr_vals = '{4'b0000, 4'b0100, 4'b1000, 4'b1001, 4'b0010, 4'b0110, 4'b1101};
        rst_n            = 1'b0;
        bus.id_valid     = 1'b0;
        bus.id_cond      = 4'h0;
        bus.id_set_flags = 1'b0;
        bus.id_is_branch = 1'b0;
        bus.exe_sr_valid = 1'b0;
        bus.exe_sr       = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk4("rst_sr", bus.sr, 4'h0);
        chk1("rst_flush", bus.flush, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk1("rst_issue", bus.issue | bus.squash | bus.stall | bus.branch_taken, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 4'h0, 0, 0, 0, 4'h0); chk1("eq_squash", bus.squash, 1'b1);
        drive(1, 4'hE, 0, 0, 0, 4'h0); chk1("al_issue", bus.issue, 1'b1);

        // ADDS then dependent BEQ
        drive(1, 4'hE, 1, 0, 0, 4'h0); chk1("adds_issue", bus.issue, 1'b1);
        drive(1, 4'h0, 0, 1, 0, 4'h0); chk1("beq_stall", bus.stall, 1'b1);
        drive(1, 4'h0, 0, 1, 1, 4'b0100);
        chk1("beq_issue", bus.issue, 1'b1);
        chk1("beq_bt", bus.branch_taken, 1'b1);
        drive(1, 4'hE, 0, 0, 0, 4'h0);
        chk4("sr_after", bus.sr, 4'b0100);
        chk1("flush1", bus.flush, 1'b1);
        chk1("flush1_sq", bus.squash, 1'b1);
        drive(1, 4'hE, 0, 0, 0, 4'h0); chk1("flush2", bus.flush, 1'b1);
        drive(0, 4'hE, 0, 0, 0, 4'h0); chk1("flush_end", bus.flush, 1'b0);

        // forwarding: 1001 gives N==V so LT fails, 1000 gives LT true
        drive(1, 4'hE, 1, 0, 0, 4'h0);
        drive(1, 4'hB, 0, 0, 1, 4'b1001);
        chk1("fwd_lt_sq", bus.squash, 1'b1);
        chk1("fwd_lt_nostall", bus.stall, 1'b0);
        drive(1, 4'hE, 1, 0, 0, 4'h0);
        drive(1, 4'hB, 0, 0, 1, 4'b1000); chk1("fwd_lt_issue", bus.issue, 1'b1);

        // capacity
        repeat (3) drive(1, 4'hE, 1, 0, 0, 4'h0);
        drive(1, 4'hE, 1, 0, 0, 4'h0); chk1("full_stall", bus.stall, 1'b1);
        drive(1, 4'hE, 1, 0, 1, 4'b0010); chk1("full_issue", bus.issue, 1'b1);
        drive(1, 4'hE, 1, 0, 0, 4'h0); chk1("still_full", bus.stall, 1'b1);
        drive(0, 4'h0, 0, 0, 1, 4'b0011);
        drive(0, 4'h0, 0, 0, 1, 4'b0101);
        drive(0, 4'h0, 0, 0, 1, 4'b0001);

        // flag return with nothing in flight
        drive(0, 4'h0, 0, 0, 1, 4'b1111);
        drive(0, 4'h0, 0, 0, 0, 4'h0);
        chk1("err_set", bus.err, 1'b1);
        chk4("err_sr", bus.sr, 4'b0001);
        drive(0, 4'h0, 0, 0, 0, 4'h0); chk1("err_sticky", bus.err, 1'b1);

        // two writers in flight: first return must not be forwarded
        drive(1, 4'hE, 1, 0, 0, 4'h0);
        drive(1, 4'hE, 1, 0, 0, 4'h0);
        drive(1, 4'h1, 0, 0, 0, 4'h0);
        drive(1, 4'h1, 0, 0, 1, 4'b0100); chk1("p2_stall", bus.stall, 1'b1);
        drive(1, 4'h1, 0, 0, 1, 4'b0000); chk1("p1_fwd_issue", bus.issue, 1'b1);

        // flag return during flush still retires the writer
        drive(1, 4'hE, 1, 0, 0, 4'h0);
        drive(1, 4'hE, 0, 1, 0, 4'h0);
        drive(1, 4'hE, 1, 0, 1, 4'b1000);
        drive(1, 4'hE, 0, 0, 0, 4'h0);
        drive(1, 4'h4, 0, 0, 0, 4'h0); chk1("mi_after_flush", bus.issue, 1'b1);

        // condition sweep over several flag values
        for (int i = 0; i < 7; i++) begin
            drive(1, 4'hE, 1, 0, 0, 4'h0);
            drive(0, 4'h0, 0, 0, 1, sr_vals[i]);
            for (int c = 0; c < 16; c++) drive(1, 4'(c), 0, 0, 0, 4'h0);
        end

        // reset in the middle of a flush
        drive(1, 4'hE, 0, 1, 0, 4'h0);
        drive(0, 4'h0, 0, 0, 0, 4'h0);
        chk1("pre_rst_flush", bus.flush, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_flush", bus.flush, 1'b0);
        chk1("rst_mid_err", bus.err, 1'b0);
        chk4("rst_mid_sr", bus.sr, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 4'h0, 0, 0, 0, 4'h0); chk1("post_rst_sq", bus.squash, 1'b1);
        drive(0, 4'h0, 0, 0, 0, 4'h0);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
